id_ex_stage: RTL and testbench
==============================

# id_ex_stage

- Decode/issue stage register directly upstream of the vector ALU.
- Each cycle it does four things:
  - accepts one 32-bit instruction word from fetch;
  - splits it into Op_code, WW, R_ins, register addresses and immediate;
  - selects each 64-bit source operand from the register file or a forwarding path;
  - registers everything into the ID/EX boundary that drives the ALU inputs.
- It owns load-use stall insertion, branch flush and downstream back-pressure for the execute pipeline.

## Interface
Parameters:
- none (widths fixed by the ISA: 32-bit instruction, 64-bit vector registers, 32 registers)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- if_instr  in  32  instruction word, bit 0 = MSB; fields: op [0:5], rD [6:10], rA [11:15], rB [16:20], WW [24:25], func [26:31], imm [16:31]
- if_valid  in  1  if_instr valid this cycle
- id_ready  out  1  stage accepts if_instr this cycle (combinational)
- rf_rA_addr, rf_rB_addr  out  5 each  register-file read addresses (combinational from if_instr)
- rf_rA_data, rf_rB_data  in  64 each  register-file read data, same cycle
- mem_fwd_en, mem_fwd_addr, mem_fwd_data  in  1/5/64  result of the ALU instruction now in MEM
- wb_fwd_en, wb_fwd_addr, wb_fwd_data  in  1/5/64  result being written back this cycle (includes load data)
- ex_stall  in  1  execute cannot accept; hold outputs
- flush  in  1  branch taken; discard in-flight ID/EX instruction
- ex_valid  out  1  outputs hold a real instruction
- Op_code  out  6  registered op
- R_ins  out  6  registered func
- WW  out  2  registered width
- rD_addr  out  5  registered destination register
- imm  out  16  registered immediate
- rA_64bit_val, rB_64bit_val  out  64 each  registered operands

## Operation
Source selection:
- rf_rA_addr = instr[11:15] for R_ALU, LOAD and STORE; instr[6:10] for BRANCH_EZ and BRANCH_NZ.
- rf_rB_addr = instr[16:20] for R_ALU; instr[6:10] for STORE; don't-care otherwise.
- Operand usage by opcode:
  - R_ALU: A and B (all funcs, including VNOT/VMOV)
  - STORE: A and B
  - LOAD: A only
  - branches: A only
  - NOP and any unlisted opcode: no operands; issue as bubble with Op_code = NOP, ex_valid = 0.

Forwarding, per operand:
- If mem_fwd_en and the address matches, use mem_fwd_data.
- Else if wb_fwd_en and the address matches, use wb_fwd_data.
- Else use rf data.
- MEM beats WB. Register 0 is an ordinary register and is forwarded like any other.

Load-use hazard:
- Detected when the current ID/EX entry has ex_valid = 1, Op_code = LOAD, and its rD_addr equals a used source address of if_instr.
- On detection: id_ready = 0, and the next edge loads a bubble (ex_valid = 0, Op_code = NOP, all other fields 0).

State machine:
- RUN → STALL1 on load-use.
- STALL1 → RUN unconditionally. In STALL1 the load data is on the WB path, so the instruction is accepted.

Priority at each edge (highest first):
1. reset
2. flush: load bubble, state → RUN, if_instr dropped, id_ready = 1 (fetch is redirected anyway)
3. ex_stall: hold all outputs and state; id_ready = 0
4. load-use: bubble
5. if_valid: issue
6. otherwise: bubble

Other rules:
- id_ready = !ex_stall && !loaduse, or 1 when flush is asserted.
- Width rules are pass-through: WW and R_ins are not interpreted here.

## Timing
- Latency: 1 cycle from acceptance to outputs.
- Throughput: 1 instruction/cycle without hazards.
- Load-use costs exactly 1 bubble.
- Reset values: ex_valid = 0, Op_code = NOP (6'b111100), R_ins = 0, WW = 0, rD_addr = 0, imm = 0, both operands = 0, state = RUN.
- Reset mid-stall: same as above.
- ex_stall lasting N cycles: outputs held N cycles, no instruction lost or duplicated.
- Forward values are sampled at the accepting edge only. During ex_stall the held operands are not refreshed; the downstream stall guarantees producers also hold.
- flush and ex_stall together: flush wins.

## Structure
- Shared package holds: opcode constants (R_ALU, LOAD, STORE, BRANCH_EZ, BRANCH_NZ, NOP), R_ins func constants, WW width constants, instruction field bit positions, the bubble value. The ALU uses the same package.
- One natural sub-module: fwd_mux (addr, rf data, two forward ports → 64-bit operand), instantiated twice.

## Test plan
- Reset then R_ALU VADD r3 = r1 + r2, WW = 2'b01, rf r1 = 0x0001…, r2 = 0x0002… → next cycle ex_valid = 1, Op_code = 6'b101010, R_ins = 6'b000110, WW = 01, operands equal rf data.
- Forward priority: r1 in rf = 0xAA…, mem_fwd r1 = 0x11…, wb_fwd r1 = 0x22… → rA_64bit_val = 0x11…; drop mem_fwd_en → 0x22….
- LOAD r5 then VADD r6 = r5 + r7 back-to-back → one bubble (ex_valid = 0, Op_code = NOP, id_ready = 0 for 1 cycle); VADD issues next with rA = wb_fwd_data.
- LOAD r5 then STORE using r5 only as base rA [11:15] → stall; LOAD r5 then VAND on r8/r9 → no stall.
- ex_stall held 3 cycles with if_valid = 1 → outputs unchanged, id_ready = 0, instruction issued once after release.
- Flush asserted together with ex_stall and a pending load-use → bubble next edge, state RUN; then reset asserted mid-stream → all outputs at reset values on next edge.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared ISA definitions for the decode/issue stage and the vector ALU.
// Field positions are given as [hi:lo] of the 32-bit word; bit 31 is ISA bit 0.
package id_ex_stage_pkg;

  localparam logic [5:0] OP_R_ALU     = 6'b101010;
  localparam logic [5:0] OP_LOAD      = 6'b100000;
  localparam logic [5:0] OP_STORE     = 6'b100001;
  localparam logic [5:0] OP_BRANCH_EZ = 6'b100010;
  localparam logic [5:0] OP_BRANCH_NZ = 6'b100011;
  localparam logic [5:0] OP_NOP       = 6'b111100;

  localparam logic [5:0] FUNC_VAND = 6'b000001;
  localparam logic [5:0] FUNC_VOR  = 6'b000010;
  localparam logic [5:0] FUNC_VXOR = 6'b000011;
  localparam logic [5:0] FUNC_VNOT = 6'b000100;
  localparam logic [5:0] FUNC_VMOV = 6'b000101;
  localparam logic [5:0] FUNC_VADD = 6'b000110;
  localparam logic [5:0] FUNC_VSUB = 6'b000111;

  localparam logic [1:0] WW_8  = 2'b00;
  localparam logic [1:0] WW_16 = 2'b01;
  localparam logic [1:0] WW_32 = 2'b10;
  localparam logic [1:0] WW_64 = 2'b11;

  localparam int OP_HI   = 31;
  localparam int OP_LO   = 26;
  localparam int RD_HI   = 25;
  localparam int RD_LO   = 21;
  localparam int RA_HI   = 20;
  localparam int RA_LO   = 16;
  localparam int RB_HI   = 15;
  localparam int RB_LO   = 11;
  localparam int WW_HI   = 7;
  localparam int WW_LO   = 6;
  localparam int FUNC_HI = 5;
  localparam int FUNC_LO = 0;
  localparam int IMM_HI  = 15;
  localparam int IMM_LO  = 0;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_STALL1 = 1'b1
  } state_e;

  typedef struct packed {
    logic        valid;
    logic [5:0]  op;
    logic [5:0]  func;
    logic [1:0]  ww;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [63:0] a;
    logic [63:0] b;
  } idex_t;

  localparam idex_t IDEX_BUBBLE = '{valid: 1'b0, op: OP_NOP, func: 6'd0, ww: 2'd0,
                                    rd: 5'd0, imm: 16'd0, a: 64'd0, b: 64'd0};

  function automatic logic is_branch(input logic [5:0] op);
    return (op == OP_BRANCH_EZ) || (op == OP_BRANCH_NZ);
  endfunction

  // Every issuable opcode reads operand A; anything else becomes a bubble.
  function automatic logic uses_a(input logic [5:0] op);
    return (op == OP_R_ALU) || (op == OP_LOAD) || (op == OP_STORE) || is_branch(op);
  endfunction

  function automatic logic uses_b(input logic [5:0] op);
    return (op == OP_R_ALU) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand source select: MEM forward beats WB forward beats register file.
module id_ex_stage_fwd_mux
  import id_ex_stage_pkg::*;
(
  input  logic [4:0]  addr_i,
  input  logic [63:0] rf_data_i,
  input  logic        mem_en_i,
  input  logic [4:0]  mem_addr_i,
  input  logic [63:0] mem_data_i,
  input  logic        wb_en_i,
  input  logic [4:0]  wb_addr_i,
  input  logic [63:0] wb_data_i,
  output logic [63:0] data_o
);

  always_comb begin
    data_o = rf_data_i;
    if (mem_en_i && (mem_addr_i == addr_i)) begin
      data_o = mem_data_i;
    end else if (wb_en_i && (wb_addr_i == addr_i)) begin
      data_o = wb_data_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode/issue stage: splits the instruction, forwards operands, and owns the
// ID/EX register with load-use stall, branch flush and execute back-pressure.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_instr,
  input  logic        if_valid,
  output logic        id_ready,
  output logic [4:0]  rf_rA_addr,
  output logic [4:0]  rf_rB_addr,
  input  logic [63:0] rf_rA_data,
  input  logic [63:0] rf_rB_data,
  input  logic        mem_fwd_en,
  input  logic [4:0]  mem_fwd_addr,
  input  logic [63:0] mem_fwd_data,
  input  logic        wb_fwd_en,
  input  logic [4:0]  wb_fwd_addr,
  input  logic [63:0] wb_fwd_data,
  input  logic        ex_stall,
  input  logic        flush,
  output logic        ex_valid,
  output logic [5:0]  Op_code,
  output logic [5:0]  R_ins,
  output logic [1:0]  WW,
  output logic [4:0]  rD_addr,
  output logic [15:0] imm,
  output logic [63:0] rA_64bit_val,
  output logic [63:0] rB_64bit_val
);

  logic [5:0]  dec_op;
  logic [4:0]  dec_rd;
  logic [4:0]  dec_ra;
  logic [4:0]  dec_rb;
  logic        use_a;
  logic        use_b;
  logic        loaduse;
  logic [63:0] opnd_a;
  logic [63:0] opnd_b;
  idex_t       idex_q;
  idex_t       idex_d;
  idex_t       issue_entry;
  state_e      state_q;
  state_e      state_d;

  assign dec_op = if_instr[OP_HI:OP_LO];
  assign dec_rd = if_instr[RD_HI:RD_LO];
  assign dec_ra = if_instr[RA_HI:RA_LO];
  assign dec_rb = if_instr[RB_HI:RB_LO];
  assign use_a  = uses_a(dec_op);
  assign use_b  = uses_b(dec_op);

  // Branches test rD; stores take their data register from rD as operand B.
  assign rf_rA_addr = is_branch(dec_op) ? dec_rd : dec_ra;
  assign rf_rB_addr = (dec_op == OP_STORE) ? dec_rd : dec_rb;

  id_ex_stage_fwd_mux u_fwd_a (
    .addr_i     (rf_rA_addr),
    .rf_data_i  (rf_rA_data),
    .mem_en_i   (mem_fwd_en),
    .mem_addr_i (mem_fwd_addr),
    .mem_data_i (mem_fwd_data),
    .wb_en_i    (wb_fwd_en),
    .wb_addr_i  (wb_fwd_addr),
    .wb_data_i  (wb_fwd_data),
    .data_o     (opnd_a)
  );

  id_ex_stage_fwd_mux u_fwd_b (
    .addr_i     (rf_rB_addr),
    .rf_data_i  (rf_rB_data),
    .mem_en_i   (mem_fwd_en),
    .mem_addr_i (mem_fwd_addr),
    .mem_data_i (mem_fwd_data),
    .wb_en_i    (wb_fwd_en),
    .wb_addr_i  (wb_fwd_addr),
    .wb_data_i  (wb_fwd_data),
    .data_o     (opnd_b)
  );

  // In STALL1 the load result is already on the WB path, so no second bubble.
  assign loaduse = if_valid && (state_q == ST_RUN) && idex_q.valid &&
                   (idex_q.op == OP_LOAD) &&
                   ((use_a && (idex_q.rd == rf_rA_addr)) ||
                    (use_b && (idex_q.rd == rf_rB_addr)));

  assign issue_entry = '{valid: 1'b1, op: dec_op, func: if_instr[FUNC_HI:FUNC_LO],
                         ww: if_instr[WW_HI:WW_LO], rd: dec_rd,
                         imm: if_instr[IMM_HI:IMM_LO], a: opnd_a, b: opnd_b};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      idex_q  <= IDEX_BUBBLE;
    end else begin
      state_q <= state_d;
      idex_q  <= idex_d;
    end
  end

  always_comb begin
    state_d = ST_RUN;
    if (flush) begin
      state_d = ST_RUN;
    end else if (ex_stall) begin
      state_d = state_q;
    end else if (loaduse) begin
      state_d = ST_STALL1;
    end
  end

  always_comb begin
    id_ready = flush || (!ex_stall && !loaduse);
    idex_d   = IDEX_BUBBLE;
    if (flush) begin
      idex_d = IDEX_BUBBLE;
    end else if (ex_stall) begin
      idex_d = idex_q;
    end else if (loaduse) begin
      idex_d = IDEX_BUBBLE;
    end else if (if_valid && use_a) begin
      idex_d = issue_entry;
    end
  end

  assign ex_valid     = idex_q.valid;
  assign Op_code      = idex_q.op;
  assign R_ins        = idex_q.func;
  assign WW           = idex_q.ww;
  assign rD_addr      = idex_q.rd;
  assign imm          = idex_q.imm;
  assign rA_64bit_val = idex_q.a;
  assign rB_64bit_val = idex_q.b;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table for the named corner cases,
// then randomized traffic checked against a rule-level reference model.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        id_ready;
  logic [4:0]  rf_rA_addr;
  logic [4:0]  rf_rB_addr;
  logic [63:0] rf_rA_data;
  logic [63:0] rf_rB_data;
  logic        mem_fwd_en;
  logic [4:0]  mem_fwd_addr;
  logic [63:0] mem_fwd_data;
  logic        wb_fwd_en;
  logic [4:0]  wb_fwd_addr;
  logic [63:0] wb_fwd_data;
  logic        ex_stall;
  logic        flush;
  logic        ex_valid;
  logic [5:0]  Op_code;
  logic [5:0]  R_ins;
  logic [1:0]  WW;
  logic [4:0]  rD_addr;
  logic [15:0] imm;
  logic [63:0] rA_64bit_val;
  logic [63:0] rB_64bit_val;

  logic [63:0] regfile [32];

  always #5 clk = ~clk;

  assign rf_rA_data = regfile[rf_rA_addr];
  assign rf_rB_data = regfile[rf_rB_addr];

  id_ex_stage dut (
    .clk          (clk),
    .reset        (reset),
    .if_instr     (if_instr),
    .if_valid     (if_valid),
    .id_ready     (id_ready),
    .rf_rA_addr   (rf_rA_addr),
    .rf_rB_addr   (rf_rB_addr),
    .rf_rA_data   (rf_rA_data),
    .rf_rB_data   (rf_rB_data),
    .mem_fwd_en   (mem_fwd_en),
    .mem_fwd_addr (mem_fwd_addr),
    .mem_fwd_data (mem_fwd_data),
    .wb_fwd_en    (wb_fwd_en),
    .wb_fwd_addr  (wb_fwd_addr),
    .wb_fwd_data  (wb_fwd_data),
    .ex_stall     (ex_stall),
    .flush        (flush),
    .ex_valid     (ex_valid),
    .Op_code      (Op_code),
    .R_ins        (R_ins),
    .WW           (WW),
    .rD_addr      (rD_addr),
    .imm          (imm),
    .rA_64bit_val (rA_64bit_val),
    .rB_64bit_val (rB_64bit_val)
  );

  typedef struct {
    bit        v;
    bit [5:0]  op;
    bit [5:0]  func;
    bit [1:0]  ww;
    bit [4:0]  rd;
    bit [15:0] imm;
    bit [63:0] a;
    bit [63:0] b;
    bit        cb;
  } exp_t;

  typedef struct {
    bit        rst;
    bit [31:0] instr;
    bit        vld;
    bit        stall;
    bit        fl;
    bit        men;
    bit [4:0]  maddr;
    bit [63:0] mdata;
    bit        wen;
    bit [4:0]  waddr;
    bit [63:0] wdata;
    bit        cr;
    bit        e_ready;
    exp_t      e;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cmp_out(input string tag, input exp_t e);
    chk({tag, ".ex_valid"}, 64'(ex_valid), 64'(e.v));
    chk({tag, ".Op_code"}, 64'(Op_code), 64'(e.op));
    chk({tag, ".R_ins"}, 64'(R_ins), 64'(e.func));
    chk({tag, ".WW"}, 64'(WW), 64'(e.ww));
    chk({tag, ".rD_addr"}, 64'(rD_addr), 64'(e.rd));
    chk({tag, ".imm"}, 64'(imm), 64'(e.imm));
    chk({tag, ".rA"}, rA_64bit_val, e.a);
    if (e.cb) chk({tag, ".rB"}, rB_64bit_val, e.b);
  endtask

  // ISA numbers bits from the MSB: field [a:b] sits at word bits [31-a:31-b].
  function automatic logic [31:0] fld(input logic [31:0] w, input int a, input int b);
    return (w >> (31 - b)) & ((32'd1 << (b - a + 1)) - 32'd1);
  endfunction

  function automatic logic [31:0] mk(input logic [5:0] op, input int rd, input int ra,
                                     input int rb, input logic [1:0] ww, input logic [5:0] fn);
    return {op, 5'(rd), 5'(ra), 5'(rb), 3'b000, ww, fn};
  endfunction

  function automatic logic [15:0] imm_of(input logic [31:0] w);
    return 16'(fld(w, 16, 31));
  endfunction

  function automatic logic [63:0] rv(input int i);
    return {4{16'(i)}};
  endfunction

  function automatic exp_t bub();
    exp_t e;
    e = '{default: 0};
    e.op = 6'b111100;
    e.cb = 1'b1;
    return e;
  endfunction

  function automatic exp_t iss(input logic [5:0] op, input logic [5:0] fn, input logic [1:0] ww,
                               input int rd, input logic [15:0] im, input logic [63:0] a,
                               input bit cb, input logic [63:0] b);
    exp_t e;
    e = '{v: 1'b1, op: op, func: fn, ww: ww, rd: 5'(rd), imm: im, a: a, b: b, cb: cb};
    return e;
  endfunction

  function automatic vec_t rowf(input bit rst, input logic [31:0] ins, input bit vld,
                                input bit st, input bit fl, input bit men, input int maddr,
                                input logic [63:0] mdata, input bit wen, input int waddr,
                                input logic [63:0] wdata, input bit cr, input bit er, input exp_t e);
    vec_t v;
    v = '{rst: rst, instr: ins, vld: vld, stall: st, fl: fl, men: men, maddr: 5'(maddr),
          mdata: mdata, wen: wen, waddr: 5'(waddr), wdata: wdata, cr: cr, e_ready: er, e: e};
    return v;
  endfunction

  function automatic vec_t row(input bit rst, input logic [31:0] ins, input bit vld,
                               input bit st, input bit fl, input bit cr, input bit er, input exp_t e);
    return rowf(rst, ins, vld, st, fl, 1'b0, 0, 64'd0, 1'b0, 0, 64'd0, cr, er, e);
  endfunction

  function automatic logic [63:0] pick(input logic [4:0] ad);
    if (mem_fwd_en && mem_fwd_addr == ad) return mem_fwd_data;
    if (wb_fwd_en && wb_fwd_addr == ad) return wb_fwd_data;
    return regfile[ad];
  endfunction

  // Reference model: what the rules say the next ID/EX contents and id_ready are.
  task automatic predict(input exp_t cur, output bit rdy, output exp_t nxt, output bit ua,
                         output bit ub, output logic [4:0] sa, output logic [4:0] sb);
    logic [5:0] op;
    logic [4:0] frd, fra, frb;
    bit haz;
    op  = 6'(fld(if_instr, 0, 5));
    frd = 5'(fld(if_instr, 6, 10));
    fra = 5'(fld(if_instr, 11, 15));
    frb = 5'(fld(if_instr, 16, 20));
    ua = 0; ub = 0; sa = 5'd0; sb = 5'd0;
    case (op)
      OP_R_ALU:                   begin ua = 1; ub = 1; sa = fra; sb = frb; end
      OP_STORE:                   begin ua = 1; ub = 1; sa = fra; sb = frd; end
      OP_LOAD:                    begin ua = 1; sa = fra; end
      OP_BRANCH_EZ, OP_BRANCH_NZ: begin ua = 1; sa = frd; end
      default:                    ;
    endcase
    haz = if_valid && cur.v && (cur.op == OP_LOAD) &&
          ((ua && cur.rd == sa) || (ub && cur.rd == sb));
    rdy = flush || (!ex_stall && !haz);
    nxt = bub();
    if (reset || flush) nxt = bub();
    else if (ex_stall) nxt = cur;
    else if (haz) nxt = bub();
    else if (if_valid && ua) begin
      nxt = iss(op, 6'(fld(if_instr, 26, 31)), 2'(fld(if_instr, 24, 25)), int'(frd),
                16'(fld(if_instr, 16, 31)), pick(sa), ub, ub ? pick(sb) : 64'd0);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    int r;
    logic [5:0] op;
    r = $urandom_range(0, 99);
    if (r < 35)      op = OP_R_ALU;
    else if (r < 60) op = OP_LOAD;
    else if (r < 75) op = OP_STORE;
    else if (r < 83) op = OP_BRANCH_EZ;
    else if (r < 90) op = OP_BRANCH_NZ;
    else if (r < 95) op = OP_NOP;
    else             op = 6'b010101;
    return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            3'($urandom), 2'($urandom), 6'($urandom)};
  endfunction

  vec_t vecs[$];
  exp_t exp_cur;

  initial begin
    logic [31:0] i_vadd3, i_vadd4, i_ld5, i_vadd6, i_st, i_vand, i_vadd11, i_bez, i_nop, i_bad;
    logic [63:0] memv, wbv, w5;
    exp_t e_vand;
    bit rdy, ua, ub, hold;
    logic [4:0] sa, sb;
    exp_t nxt;

    for (int i = 0; i < 32; i++) regfile[i] = rv(i);
    memv = 64'h1111_1111_1111_1111;
    wbv  = 64'h2222_2222_2222_2222;
    w5   = 64'h5555_5555_5555_5555;
    i_vadd3  = mk(OP_R_ALU, 3, 1, 2, WW_16, FUNC_VADD);
    i_vadd4  = mk(OP_R_ALU, 4, 1, 2, WW_16, FUNC_VADD);
    i_ld5    = mk(OP_LOAD, 5, 1, 0, WW_8, 6'd0);
    i_vadd6  = mk(OP_R_ALU, 6, 5, 7, WW_16, FUNC_VADD);
    i_st     = mk(OP_STORE, 8, 5, 0, WW_8, 6'd0);
    i_vand   = mk(OP_R_ALU, 10, 8, 9, WW_64, FUNC_VAND);
    i_vadd11 = mk(OP_R_ALU, 11, 1, 2, WW_16, FUNC_VADD);
    i_bez    = mk(OP_BRANCH_EZ, 5, 0, 0, WW_8, 6'd0);
    i_nop    = mk(OP_NOP, 0, 0, 0, WW_8, 6'd0);
    i_bad    = mk(6'b000111, 3, 1, 2, WW_8, 6'd0);
    e_vand   = iss(6'b101010, FUNC_VAND, WW_64, 10, imm_of(i_vand), rv(8), 1, rv(9));

    vecs.push_back(row(0, i_vadd3, 1, 0, 0, 1, 1,
                       iss(6'b101010, 6'b000110, 2'b01, 3, imm_of(i_vadd3), rv(1), 1, rv(2))));
    vecs.push_back(rowf(0, i_vadd4, 1, 0, 0, 1, 1, memv, 1, 1, wbv, 1, 1,
                        iss(OP_R_ALU, FUNC_VADD, WW_16, 4, imm_of(i_vadd4), memv, 1, rv(2))));
    vecs.push_back(rowf(0, i_vadd4, 1, 0, 0, 0, 1, memv, 1, 1, wbv, 1, 1,
                        iss(OP_R_ALU, FUNC_VADD, WW_16, 4, imm_of(i_vadd4), wbv, 1, rv(2))));
    vecs.push_back(row(0, i_ld5, 1, 0, 0, 1, 1, iss(OP_LOAD, 6'd0, 2'd0, 5, 16'd0, rv(1), 0, 0)));
    vecs.push_back(row(0, i_vadd6, 1, 0, 0, 1, 0, bub()));
    vecs.push_back(rowf(0, i_vadd6, 1, 0, 0, 0, 0, 0, 1, 5, w5, 1, 1,
                        iss(OP_R_ALU, FUNC_VADD, WW_16, 6, imm_of(i_vadd6), w5, 1, rv(7))));
    vecs.push_back(row(0, i_ld5, 1, 0, 0, 1, 1, iss(OP_LOAD, 6'd0, 2'd0, 5, 16'd0, rv(1), 0, 0)));
    vecs.push_back(row(0, i_st, 1, 0, 0, 1, 0, bub()));
    vecs.push_back(rowf(0, i_st, 1, 0, 0, 0, 0, 0, 1, 5, w5, 1, 1,
                        iss(OP_STORE, 6'd0, 2'd0, 8, 16'd0, w5, 1, rv(8))));
    vecs.push_back(row(0, i_ld5, 1, 0, 0, 1, 1, iss(OP_LOAD, 6'd0, 2'd0, 5, 16'd0, rv(1), 0, 0)));
    vecs.push_back(row(0, i_vand, 1, 0, 0, 1, 1, e_vand));
    for (int k = 0; k < 3; k++) vecs.push_back(row(0, i_vadd11, 1, 1, 0, 1, 0, e_vand));
    vecs.push_back(row(0, i_vadd11, 1, 0, 0, 1, 1,
                       iss(OP_R_ALU, FUNC_VADD, WW_16, 11, imm_of(i_vadd11), rv(1), 1, rv(2))));
    vecs.push_back(row(0, i_vadd11, 0, 0, 0, 1, 1, bub()));
    vecs.push_back(row(0, i_ld5, 1, 0, 0, 1, 1, iss(OP_LOAD, 6'd0, 2'd0, 5, 16'd0, rv(1), 0, 0)));
    vecs.push_back(row(0, i_vadd6, 1, 1, 1, 1, 1, bub()));
    vecs.push_back(row(0, i_vadd6, 1, 0, 0, 1, 1,
                       iss(OP_R_ALU, FUNC_VADD, WW_16, 6, imm_of(i_vadd6), rv(5), 1, rv(7))));
    vecs.push_back(row(0, i_ld5, 1, 0, 0, 1, 1, iss(OP_LOAD, 6'd0, 2'd0, 5, 16'd0, rv(1), 0, 0)));
    vecs.push_back(row(0, i_vadd6, 1, 0, 0, 1, 0, bub()));
    vecs.push_back(rowf(0, i_vadd6, 1, 0, 0, 0, 0, 0, 1, 5, w5, 1, 1,
                        iss(OP_R_ALU, FUNC_VADD, WW_16, 6, imm_of(i_vadd6), w5, 1, rv(7))));
    vecs.push_back(row(0, i_ld5, 1, 0, 0, 1, 1, iss(OP_LOAD, 6'd0, 2'd0, 5, 16'd0, rv(1), 0, 0)));
    vecs.push_back(row(1, i_vadd6, 1, 0, 0, 0, 0, bub()));
    vecs.push_back(row(0, i_vadd6, 1, 0, 0, 1, 1,
                       iss(OP_R_ALU, FUNC_VADD, WW_16, 6, imm_of(i_vadd6), rv(5), 1, rv(7))));
    vecs.push_back(row(0, i_nop, 1, 0, 0, 1, 1, bub()));
    vecs.push_back(row(0, i_bad, 1, 0, 0, 1, 1, bub()));
    vecs.push_back(row(0, i_ld5, 1, 0, 0, 1, 1, iss(OP_LOAD, 6'd0, 2'd0, 5, 16'd0, rv(1), 0, 0)));
    vecs.push_back(row(0, i_bez, 1, 0, 0, 1, 0, bub()));
    vecs.push_back(rowf(0, i_bez, 1, 0, 0, 0, 0, 0, 1, 5, w5, 1, 1,
                        iss(OP_BRANCH_EZ, 6'd0, 2'd0, 5, 16'd0, w5, 0, 0)));

    reset = 1'b1; if_instr = 32'd0; if_valid = 1'b0; ex_stall = 1'b0; flush = 1'b0;
    mem_fwd_en = 1'b0; mem_fwd_addr = 5'd0; mem_fwd_data = 64'd0;
    wb_fwd_en = 1'b0; wb_fwd_addr = 5'd0; wb_fwd_data = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.ex_valid", 64'(ex_valid), 64'd0);
    chk("reset.Op_code", 64'(Op_code), 64'(6'b111100));
    chk("reset.R_ins", 64'(R_ins), 64'd0);
    chk("reset.WW", 64'(WW), 64'd0);
    chk("reset.rD_addr", 64'(rD_addr), 64'd0);
    chk("reset.imm", 64'(imm), 64'd0);
    chk("reset.rA", rA_64bit_val, 64'd0);
    chk("reset.rB", rB_64bit_val, 64'd0);
    $display("reset: ex_valid=%0b Op_code=%b", ex_valid, Op_code);

    foreach (vecs[n]) begin
      reset = vecs[n].rst; if_instr = vecs[n].instr; if_valid = vecs[n].vld;
      ex_stall = vecs[n].stall; flush = vecs[n].fl;
      mem_fwd_en = vecs[n].men; mem_fwd_addr = vecs[n].maddr; mem_fwd_data = vecs[n].mdata;
      wb_fwd_en = vecs[n].wen; wb_fwd_addr = vecs[n].waddr; wb_fwd_data = vecs[n].wdata;
      #1;
      if (vecs[n].cr) chk($sformatf("vec%0d.id_ready", n), 64'(id_ready), 64'(vecs[n].e_ready));
      @(posedge clk);
      #1;
      cmp_out($sformatf("vec%0d", n), vecs[n].e);
      $display("vec %0d: instr=%h ready=%0b ex_valid=%0b Op_code=%b rD=%0d rA=%h rB=%h",
               n, vecs[n].instr, vecs[n].e_ready, ex_valid, Op_code, rD_addr,
               rA_64bit_val, rB_64bit_val);
    end

    for (int i = 0; i < 32; i++) regfile[i] = {$urandom, $urandom};
    exp_cur = bub();
    hold = 0;
    for (int c = 0; c < 400; c++) begin
      reset = (c == 0) || ($urandom_range(0, 99) < 2);
      if (!hold) begin
        if_instr = rand_instr();
        if_valid = $urandom_range(0, 99) < 85;
      end
      ex_stall     = $urandom_range(0, 99) < 20;
      flush        = $urandom_range(0, 99) < 5;
      mem_fwd_en   = $urandom_range(0, 1) == 1;
      mem_fwd_addr = 5'($urandom_range(0, 3));
      mem_fwd_data = {$urandom, $urandom};
      wb_fwd_en    = $urandom_range(0, 1) == 1;
      wb_fwd_addr  = 5'($urandom_range(0, 3));
      wb_fwd_data  = {$urandom, $urandom};
      #1;
      predict(exp_cur, rdy, nxt, ua, ub, sa, sb);
      if (!reset) chk($sformatf("rnd%0d.id_ready", c), 64'(id_ready), 64'(rdy));
      if (ua) chk($sformatf("rnd%0d.rf_rA_addr", c), 64'(rf_rA_addr), 64'(sa));
      if (ub) chk($sformatf("rnd%0d.rf_rB_addr", c), 64'(rf_rB_addr), 64'(sb));
      @(posedge clk);
      #1;
      exp_cur = nxt;
      cmp_out($sformatf("rnd%0d", c), exp_cur);
      $display("rnd %0d: instr=%h v=%0b st=%0b fl=%0b rst=%0b -> ex_valid=%0b Op_code=%b",
               c, if_instr, if_valid, ex_stall, flush, reset, ex_valid, Op_code);
      hold = !reset && !rdy && if_valid;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
